calc_mode_ctrl: RTL

- Sequencing controller for the switch calculator datapath (arithmetic, logical and comparison units feeding the result mux and seven-segment decode).
- Replaces the raw pushbutton toggle latches with a clocked path: synchronise, debounce, edge-detect, then a mode state machine that drives the 2-bit mux select.
- Adds an operand hold function so the displayed result can be frozen while the switches move.

---
 rtl/calc_mode_ctrl_if.sv | 25 ++
 rtl/calc_mode_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/calc_mode_ctrl_if.sv
// Calculator control bus: raw buttons and switches in, mux select, operand
// bus and status out.
interface calc_mode_ctrl_if #(
  parameter int SW_W = 10
);
  logic [1:0]      PB;
  logic [SW_W-1:0] SW;
  logic [1:0]      sel;
  logic [SW_W-1:0] op;
  logic            held;
  logic            mode_chg;
  logic [1:0]      press;

  // The board/stimulus side drives the buttons and switches.
  modport master (
    output PB, SW,
    input  sel, op, held, mode_chg, press
  );

  // The controller consumes the buttons and switches and drives the datapath.
  modport slave (
    input  PB, SW,
    output sel, op, held, mode_chg, press
  );
endinterface

// File: rtl/calc_mode_ctrl.sv
// Sequencing controller for the switch calculator datapath.
// Each pushbutton is synchronised, debounced and edge-detected into a
// one-cycle press pulse. PB[0] steps the datapath mode (arith -> logic ->
// compare). PB[1] toggles an operand hold that freezes op while the
// switches move.
module calc_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,  // must be >= 2
  parameter int SW_W            = 10
) (
  input logic            clk,
  input logic            rst,
  calc_mode_ctrl_if.slave bus
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The mode encoding is the mux select itself, so sel needs no decode.
  typedef enum logic [1:0] {
    ARITH   = 2'b00,
    LOGIC   = 2'b01,
    CMP     = 2'b10,
    ILLEGAL = 2'b11
  } mode_t;

  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [1:0]       press_q;
  logic [CNT_W-1:0] cnt [2];

  mode_t            mode;
  logic             mode_chg_q;
  logic             held_q;
  logic [SW_W-1:0]  op_q;

  // Synchronise, debounce and detect the debounced press edge per button.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, which makes the two-flop synchroniser a real
  // two-stage pipeline instead of collapsing into one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the buttons are active-low, so "released" is all ones; resetting
      // these to 0 would fake a press straight out of reset.
      sync1   <= '1;
      sync2   <= '1;
      deb     <= '1;
      press_q <= '0;
      cnt[0]  <= '0;
      cnt[1]  <= '0;
    end else begin
      sync1 <= bus.PB;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          // This edge is the one on which the count would reach
          // DEBOUNCE_CYCLES, so accept the new level here.
          deb[i]     <= sync2[i];
          cnt[i]     <= '0;
          press_q[i] <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Mode state machine plus operand hold; every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode       <= ARITH;
      mode_chg_q <= 1'b0;
      held_q     <= 1'b0;
      op_q       <= '0;
    end else begin
      mode_chg_q <= 1'b0;
      unique case (mode)
        ARITH: if (press_q[0]) begin mode <= LOGIC; mode_chg_q <= 1'b1; end
        LOGIC: if (press_q[0]) begin mode <= CMP;   mode_chg_q <= 1'b1; end
        CMP:   if (press_q[0]) begin mode <= ARITH; mode_chg_q <= 1'b1; end
        default: begin
          // Recover from the unused code regardless of the buttons.
          mode       <= ARITH;
          mode_chg_q <= 1'b1;
        end
      endcase

      if (press_q[1]) held_q <= ~held_q;

      // Load while live, on the freeze edge (captures this cycle's SW) and on
      // the release edge (SW appears together with held dropping).
      if (!held_q || press_q[1]) op_q <= bus.SW;
    end
  end

  assign bus.sel      = mode;
  assign bus.mode_chg = mode_chg_q;
  assign bus.held     = held_q;
  assign bus.op       = op_q;
  assign bus.press    = press_q;

endmodule
